// File: rtl/demux_val_rdy_1ton.sv
// demux_val_rdy_1ton: registered 1-to-N val/rdy demux with one-entry buffer per channel and invalid-select drop counter
module demux_val_rdy_1ton #(
  parameter int nbits = 4,
  parameter int nports = 5,
  localparam int sbits = (nports > 1) ? $clog2(nports) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [nbits-1:0]        in_msg,
  input  logic [sbits-1:0]        in_sel,
  output logic [nports-1:0]       out_val,
  input  logic [nports-1:0]       out_rdy,
  output logic [nports*nbits-1:0] out_msg,
  output logic [7:0]              drop_count
);
  logic [nports-1:0] full;
  logic [nports-1:0][nbits-1:0] data;
  logic [(1<<sbits)-1:0] full_p, rdy_p;
  logic sel_ok, in_fire;
  // pad to the full select range so out-of-range selects index defined bits
  always_comb begin
    full_p = '0;
    rdy_p = '0;
    full_p[nports-1:0] = full;
    rdy_p[nports-1:0] = out_rdy;
  end
  assign sel_ok = int'(in_sel) < nports;
  assign in_rdy = !reset && (!sel_ok || !full_p[in_sel] || rdy_p[in_sel]);
  assign in_fire = in_val && in_rdy;
  assign out_val = full;
  assign out_msg = data;
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      data <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < nports; i++) begin
        if (in_fire && sel_ok && int'(in_sel) == i) begin
          full[i] <= 1'b1;
          data[i] <= in_msg;
        end else if (full[i] && out_rdy[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (in_fire && !sel_ok && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end
endmodule
